guarded_proxy_mem: RTL

//   Multi-channel shared memory with origin-checked writes. NUM_CH requesters share one array.

---
 rtl/guarded_proxy_pkg.sv | 10 +
 rtl/guarded_proxy_mem_rr_arbiter.sv | 31 +++
 rtl/guarded_proxy_mem.sv | 102 ++++++++++
 3 files changed

// File: rtl/guarded_proxy_pkg.sv
// guarded_proxy_pkg: shared types and constants for guarded_proxy_mem.
package guarded_proxy_pkg;
  localparam int AUDIT_W = 16;
  localparam int ORIGIN_W = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic write;
    logic [ORIGIN_W-1:0] origin;
  } req_t;
endpackage

// File: rtl/guarded_proxy_mem_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at an internal pointer that moves past each winner.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);
  logic [CH_W-1:0] ptr, widx, idx;
  logic found;
  always_comb begin
    grant = '0;
    widx = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        widx = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (advance && found) ptr <= (widx == CH_W'(NUM_CH - 1)) ? '0 : widx + 1'b1;
endmodule

// File: rtl/guarded_proxy_mem.sv
// guarded_proxy_mem: shared memory whose writes need permission for both the channel and the agent it acts for.
// Define PROXY_AUDIT_EN to add the denied-write audit outputs.
module guarded_proxy_mem
  import guarded_proxy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH = 4,
  parameter int REGION_BITS = 2,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int NUM_REG = 2 ** REGION_BITS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_CH*CH_W-1:0]       req_origin,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [CH_W-1:0]              rsp_ch,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  input  logic                         cfg_we,
  input  logic [REGION_BITS-1:0]       cfg_region,
  input  logic [NUM_CH-1:0]            cfg_mask
`ifdef PROXY_AUDIT_EN
  ,
  output logic [AUDIT_W-1:0]           audit_count,
  output logic [ADDR_WIDTH-1:0]        audit_last_addr,
  output logic [CH_W-1:0]              audit_last_origin
`endif
);
  state_t state, state_nxt;
  req_t cur;
  logic idle, permit, deny;
  logic [NUM_CH-1:0] grant, mask_r;
  logic [CH_W-1:0] widx, ch;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NUM_REG-1:0][NUM_CH-1:0] mask;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk(clk), .reset_n(reset_n), .req(req_valid), .advance(idle), .grant(grant)
  );
  always_comb begin
    widx = '0;
    for (int i = 0; i < NUM_CH; i++) if (grant[i]) widx = widx | CH_W'(i);
    idle = state == IDLE;
    state_nxt = idle ? (|req_valid ? ACCESS : IDLE)
              : state == ACCESS ? RESP : (rsp_ready ? IDLE : RESP);
    req_ready = idle ? grant : '0;
    rsp_valid = state == RESP;
    // Both the acting channel and the agent it claims to act for must hold write permission.
    mask_r = mask[addr[ADDR_WIDTH-1 -: REGION_BITS]];
    permit = (cur.origin < ORIGIN_W'(NUM_CH)) && |(mask_r & (NUM_CH'(1) << cur.origin))
             && |(mask_r & (NUM_CH'(1) << ch));
    deny = cur.write && !permit;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cur <= '0;
      ch <= '0;
      addr <= '0;
      wdata <= '0;
      mask <= '0;
      rsp_ch <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_we) mask[cfg_region] <= cfg_mask;
      if (idle && |req_valid) begin
        cur <= '{write: req_write[widx], origin: ORIGIN_W'(req_origin[widx*CH_W +: CH_W])};
        ch <= widx;
        addr <= req_addr[widx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata <= req_wdata[widx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == ACCESS) begin
        rsp_ch <= ch;
        rsp_err <= deny;
        rsp_rdata <= cur.write ? '0 : mem[addr];
      end
    end
  always_ff @(posedge clk)
    if (state == ACCESS && cur.write && permit) mem[addr] <= wdata;
`ifdef PROXY_AUDIT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      audit_count <= '0;
      audit_last_addr <= '0;
      audit_last_origin <= '0;
    end else if (state == ACCESS && deny) begin
      if (audit_count != '1) audit_count <= audit_count + 1'b1;
      audit_last_addr <= addr;
      audit_last_origin <= cur.origin[CH_W-1:0];
    end
`endif
endmodule
